// File: rtl/nn_done_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : nn_done_tracker
//  Purpose  : Runs the accelerator layers of one inference in sequence. It
//             issues one layer_start pulse per layer and waits for that
//             layer's layer_done. After the last layer it holds a
//             level-sensitive done flag for the processor's done PIO until
//             software acks it. It also flags a hung layer (error) and
//             measures the inference latency in cycles.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   1       system clock
//    reset        in   1       asynchronous, active-high reset
//    start        in   1       one-cycle PIO request; starts a pass (IDLE only)
//    ack          in   1       one-cycle PIO clear; releases done / error
//    layer_done   in   1       one-cycle pulse: current layer finished
//    layer_start  out  1       one-cycle pulse: begin layer layer_idx
//    layer_idx    out  LIDX_W  index of the layer being run
//    busy         out  1       high while issuing or waiting on a layer
//    done         out  1       level; inference complete
//    error        out  1       level; a layer timed out
//    cycle_count  out  32      cycles from first layer_start to completion
// ============================================================================
module nn_done_tracker #(
  parameter int NUM_LAYERS     = 3,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int LIDX_W         = 2,
  parameter int TO_W           = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              ack,
  input  logic              layer_done,
  output logic              layer_start,
  output logic [LIDX_W-1:0] layer_idx,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [31:0]       cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  localparam logic [LIDX_W-1:0] LAST_IDX = LIDX_W'(NUM_LAYERS - 1);
  localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]       CC_MAX   = 32'hFFFF_FFFF;

  state_t            state;
  state_t            state_nx;
  logic [LIDX_W-1:0] idx_nx;
  logic [TO_W-1:0]   to_cnt;
  logic [TO_W-1:0]   to_nx;
  logic [31:0]       cc_nx;

  // Next-state and next-value logic.
  always_comb begin
    state_nx = state;
    idx_nx   = layer_idx;
    to_nx    = to_cnt;
    cc_nx    = cycle_count;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nx = S_ISSUE;
          idx_nx   = '0;
          cc_nx    = '0;
        end
      end
      S_ISSUE: begin
        state_nx = S_WAIT;
        to_nx    = '0;
      end
      S_WAIT: begin
        // A completion arriving on the last allowed cycle beats the timeout.
        if (layer_done) begin
          if (layer_idx == LAST_IDX) begin
            state_nx = S_DONE;
          end else begin
            state_nx = S_ISSUE;
            idx_nx   = layer_idx + LIDX_W'(1);
          end
        end else if (to_cnt == TO_LAST) begin
          state_nx = S_ERR;
        end else begin
          to_nx = to_cnt + TO_W'(1);
        end
      end
      S_DONE, S_ERR: begin
        // ack wins over a coincident start; the start is simply dropped.
        if (ack) begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase

    // Latency counts every active cycle and sticks at all-ones.
    if ((state == S_ISSUE || state == S_WAIT) && (cycle_count != CC_MAX)) begin
      cc_nx = cycle_count + 32'd1;
    end
  end

  // State, counters and registered outputs. Outputs are decoded from the
  // next state so each one is valid in the same cycle as the state it marks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      layer_idx   <= '0;
      to_cnt      <= '0;
      cycle_count <= '0;
      layer_start <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
    end else begin
      state       <= state_nx;
      layer_idx   <= idx_nx;
      to_cnt      <= to_nx;
      cycle_count <= cc_nx;
      layer_start <= (state_nx == S_ISSUE);
      busy        <= (state_nx == S_ISSUE) || (state_nx == S_WAIT);
      done        <= (state_nx == S_DONE);
      error       <= (state_nx == S_ERR);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nn_done_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nn_done_tracker
//  Purpose  : Directed bench for nn_done_tracker (3 layers, timeout 16).
//             Stimulus pushes the expected layer_start / done / error events
//             with their cycle numbers; a monitor pops and compares them.
//  Revision : 1.0  initial release
// ============================================================================
module tb_nn_done_tracker;

  localparam int NL = 3;
  localparam int TO = 16;

  localparam int EV_LS   = 0;
  localparam int EV_DONE = 1;
  localparam int EV_ERR  = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        ack;
  logic        layer_done;
  logic        layer_start;
  logic [1:0]  layer_idx;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] cycle_count;

  nn_done_tracker #(
    .NUM_LAYERS     (NL),
    .TIMEOUT_CYCLES (TO),
    .LIDX_W         (2),
    .TO_W           (5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .ack         (ack),
    .layer_done  (layer_done),
    .layer_start (layer_start),
    .layer_idx   (layer_idx),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int idx;
    int cyc;
    int cc;   // -1: not checked
  } ev_t;

  ev_t q[$];
  int  n_chk  = 0;
  int  n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic push(input int kind, input int idx, input int at, input int cc);
    ev_t e;
    e.kind = kind; e.idx = idx; e.cyc = at; e.cc = cc;
    q.push_back(e);
  endtask

  // Monitor: every observed event must match the head of the queue.
  logic prev_done = 1'b0;
  logic prev_err  = 1'b0;
  always @(negedge clk) begin
    int  kind;
    ev_t e;
    kind = -1;
    if (layer_start) kind = EV_LS;
    else if (done && !prev_done) kind = EV_DONE;
    else if (error && !prev_err) kind = EV_ERR;
    if (kind >= 0) begin
      if (q.size() == 0) begin
        chk($sformatf("unexpected_event_k%0d_c%0d", kind, cyc), 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk($sformatf("ev_kind_c%0d", e.cyc), kind, e.kind);
        chk($sformatf("ev_idx_c%0d", e.cyc), {30'd0, layer_idx}, e.idx);
        chk($sformatf("ev_cycle_k%0d", e.kind), cyc, e.cyc);
        if (e.cc >= 0) chk($sformatf("ev_cc_c%0d", e.cyc), cycle_count, e.cc);
      end
    end
    prev_done = done;
    prev_err  = error;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // start asserted in the current cycle; returns in the ISSUE cycle.
  task automatic drive_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  // From an ISSUE cycle: wait n cycles, pulse layer_done, land one cycle later.
  task automatic do_layer(input int n);
    repeat (n) tick();
    layer_done = 1'b1; tick(); layer_done = 1'b0;
  endtask

  task automatic do_ack();
    ack = 1'b1; tick(); ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int c;
    reset = 1'b1; start = 1'b0; ack = 1'b0; layer_done = 1'b0;
    repeat (2) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", error, 0);
    chk("rst_cc", cycle_count, 0);
    chk("rst_idx", layer_idx, 0);
    reset = 1'b0;
    repeat (2) tick();

    // 1. Nominal pass: 5 cycles from each layer_start to layer_done.
    c = cyc;
    push(EV_LS, 0, c + 1, 0);
    push(EV_LS, 1, c + 7, 6);
    push(EV_LS, 2, c + 13, 12);
    push(EV_DONE, 2, c + 19, 18);
    drive_start();
    chk("t1_busy_issue", busy, 1);
    do_layer(5); do_layer(5); do_layer(5);
    chk("t1_done", done, 1);
    chk("t1_busy_done", busy, 0);
    chk("t1_err", error, 0);
    do_ack();
    chk("t1_done_clr", done, 0);
    chk("t1_busy_idle", busy, 0);
    chk("t1_cc_held", cycle_count, 18);
    chk("t1_idx_held", layer_idx, 2);
    tick();

    // 2. Timeout on layer 1.
    c = cyc;
    push(EV_LS, 0, c + 1, 0);
    push(EV_LS, 1, c + 4, 3);
    push(EV_ERR, 1, c + 21, 20);
    drive_start();
    do_layer(2);
    repeat (16) tick();
    chk("t2_err_not_yet", error, 0);
    tick();
    chk("t2_err", error, 1);
    chk("t2_done", done, 0);
    chk("t2_idx", layer_idx, 1);
    chk("t2_busy", busy, 0);
    tick();
    chk("t2_cc_frozen", cycle_count, 20);
    do_ack();
    chk("t2_err_clr", error, 0);
    tick();

    // 3. Spurious inputs: layer_done in IDLE, start in WAIT, layer_done in DONE.
    layer_done = 1'b1; tick(); layer_done = 1'b0;
    chk("t3_idle_busy", busy, 0);
    chk("t3_idle_idx", layer_idx, 1);
    c = cyc;
    push(EV_LS, 0, c + 1, 0);
    push(EV_LS, 1, c + 5, 4);
    push(EV_LS, 2, c + 7, 6);
    push(EV_DONE, 2, c + 9, 8);
    drive_start();
    tick();
    start = 1'b1; tick(); start = 1'b0;
    chk("t3_wait_idx", layer_idx, 0);
    do_layer(1);
    do_layer(1);
    do_layer(1);
    chk("t3_done", done, 1);
    layer_done = 1'b1; tick(); layer_done = 1'b0;
    chk("t3_done_hold", done, 1);
    chk("t3_done_idx", layer_idx, 2);
    chk("t3_done_cc", cycle_count, 8);

    // 4a. ack and start together in DONE: back to IDLE, no new pass.
    ack = 1'b1; start = 1'b1; tick(); ack = 1'b0; start = 1'b0;
    chk("t4_ackstart_done", done, 0);
    chk("t4_ackstart_busy", busy, 0);
    repeat (3) tick();
    chk("t4_still_idle", busy, 0);

    // 4b. layer_done on the final timeout cycle wins over the timeout.
    c = cyc;
    push(EV_LS, 0, c + 1, 0);
    push(EV_LS, 1, c + 18, 17);
    push(EV_LS, 2, c + 20, 19);
    push(EV_DONE, 2, c + 22, 21);
    drive_start();
    do_layer(TO);
    chk("t4_no_err", error, 0);
    chk("t4_progress_idx", layer_idx, 1);
    do_layer(1);
    do_layer(1);
    chk("t4_done", done, 1);
    chk("t4_done_err", error, 0);
    do_ack();
    tick();

    // 5. Asynchronous reset while waiting on layer 1.
    c = cyc;
    push(EV_LS, 0, c + 1, 0);
    push(EV_LS, 1, c + 3, 2);
    drive_start();
    do_layer(1);
    tick();
    #2 reset = 1'b1;
    #1;
    chk("t5_async_busy", busy, 0);
    chk("t5_async_idx", layer_idx, 0);
    chk("t5_async_cc", cycle_count, 0);
    chk("t5_async_ls", layer_start, 0);
    chk("t5_async_flags", {30'd0, done, error}, 0);
    tick();
    reset = 1'b0;
    repeat (4) tick();
    chk("t5_idle_after", busy, 0);

    // 6. Back-to-back: ack, then start on the very next cycle.
    c = cyc;
    push(EV_LS, 0, c + 1, 0);
    push(EV_LS, 1, c + 3, 2);
    push(EV_LS, 2, c + 5, 4);
    push(EV_DONE, 2, c + 7, 6);
    push(EV_LS, 0, c + 9, 0);
    push(EV_LS, 1, c + 11, 2);
    push(EV_LS, 2, c + 13, 4);
    push(EV_DONE, 2, c + 15, 6);
    drive_start();
    do_layer(1); do_layer(1); do_layer(1);
    do_ack();
    drive_start();
    chk("t6_restart_idx", layer_idx, 0);
    chk("t6_restart_cc", cycle_count, 0);
    do_layer(1); do_layer(1); do_layer(1);
    chk("t6_done2", done, 1);
    do_ack();
    repeat (3) tick();

    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
